// File: rtl/rv_pkg.sv
// rv_pkg: RV32I constants and helpers shared by the fetch unit and the
// control unit.
//   - RV_XLEN / RV_RESET_PC : default datapath width and boot address
//   - opcode_e              : major opcodes decoded by the control unit
//   - *_LSB                 : bit offsets of the fixed instruction fields
//   - get_opcode/funct3/7   : field extraction helpers
package rv_pkg;

    localparam int unsigned RV_XLEN     = 32;
    localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111
    } opcode_e;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned FUNCT7_LSB = 25;

    typedef logic [31:0] instr_t;

    function automatic logic [6:0] get_opcode(input instr_t instr);
        return instr[OPCODE_LSB +: 7];
    endfunction

    function automatic logic [2:0] get_funct3(input instr_t instr);
        return instr[FUNCT3_LSB +: 3];
    endfunction

    function automatic logic [6:0] get_funct7(input instr_t instr);
        return instr[FUNCT7_LSB +: 7];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus bundle between the fetch unit, instruction memory,
// execute (redirects) and decode.
//   imem_req_*   : fetch request (valid/ready, word-aligned address)
//   imem_rsp_*   : in-order read data, never back-pressured
//   redirect_*   : single-cycle branch/jump redirect from execute
//   out_*        : instruction + PC + decoded fields to decode (valid/ready)
// modport master = fetch unit side, modport slave = environment side.
interface fetch_unit_if #(
    parameter int unsigned XLEN = 32
);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;

    modport master (
        output imem_req_valid, imem_req_addr,
        output out_valid, out_instr, out_pc, out_opcode, out_funct3, out_funct7,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  out_valid, out_instr, out_pc, out_opcode, out_funct3, out_funct7,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush.
//   clk, rst         : clock, synchronous active-high reset
//   flush            : drop all entries (pointers return to zero)
//   push, push_data  : write an entry (ignored when full unless popping)
//   pop              : remove the head entry (ignored when empty)
//   head_data        : current head entry (combinational read)
//   full/empty/count : occupancy status
// Storage is cleared on reset so the head reads as zero until the first write.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags, qualified push/pop and next-state pointers/storage.
    always_comb begin
        full      = (cnt_q == CW'(DEPTH));
        empty     = (cnt_q == '0);
        // A push into a full FIFO is allowed only when the head leaves the same cycle.
        do_push_s = push && (!full || pop);
        do_pop_s  = pop && !empty;
        mem_d     = mem_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + AW'(1);
            end else begin
                wr_d        = wr_q;
            end
            if (do_pop_s) begin
                rd_d = rd_q + AW'(1);
            end else begin
                rd_d = rd_q;
            end
            cnt_d = cnt_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_data = mem_q[rd_q];
    assign count     = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch front end.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : fetch_unit_if.master
//              - issues sequential word-aligned fetches (imem_req_*)
//              - buffers in-order responses (imem_rsp_*) with their PCs
//              - presents instr/pc/opcode/funct3/funct7 to decode (out_*)
//              - redirect_* flushes the buffer and restarts at the target;
//                responses of fetches already in flight are discarded
// A request is issued only while outstanding + buffered < DEPTH, so every
// response always finds a free buffer slot.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN     = RV_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RV_RESET_PC),
    parameter int unsigned     DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = 32 + XLEN;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW:0]     inflight_s;
    logic            credit_ok_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            rsp_seen_s;
    logic            rsp_keep_s;
    logic            out_valid_s;
    logic            out_pop_s;
    logic [XLEN-1:0] redir_pc_s;
    logic [XLEN-1:0] tag_pc_s;
    logic [EW-1:0]   head_s;
    logic [EW-1:0]   out_entry_s;
    logic [CW-1:0]   buf_count_s;
    logic            buf_empty_s;
    logic            tag_empty_s;
    logic [CW-1:0]   tag_count_unused;
    logic            buf_full_unused;
    logic            tag_full_unused;

    // Credit check, response filtering and output handshake qualification.
    always_comb begin
        inflight_s  = {1'b0, outst_q} + {1'b0, buf_count_s};
        credit_ok_s = (inflight_s < (CW+1)'(DEPTH));
        req_valid_s = !rst && !bus.redirect_valid && credit_ok_s;
        req_fire_s  = req_valid_s && bus.imem_req_ready;
        // A response with nothing outstanding cannot belong to us; ignore it.
        rsp_seen_s  = bus.imem_rsp_valid && (outst_q != '0);
        // Stale data (older than a redirect) is dropped instead of buffered.
        rsp_keep_s  = rsp_seen_s && !bus.redirect_valid && (drop_q == '0) && !tag_empty_s;
        out_valid_s = !rst && !buf_empty_s && !bus.redirect_valid;
        out_pop_s   = out_valid_s && bus.out_ready;
        redir_pc_s  = bus.redirect_pc & ~XLEN'(32'd3);
        out_entry_s = rst ? '0 : head_s;
    end

    // Next PC, outstanding-request count and stale-response drop count.
    always_comb begin
        outst_d = outst_q + CW'(req_fire_s) - CW'(rsp_seen_s);
        if (bus.redirect_valid) begin
            pc_d   = redir_pc_s;
            // Everything still in flight after this cycle belongs to the old path.
            drop_d = outst_q - CW'(rsp_seen_s);
        end else begin
            if (req_fire_s) begin
                pc_d = pc_q + XLEN'(32'd4);
            end else begin
                pc_d = pc_q;
            end
            if (rsp_seen_s && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    // PC of every issued request, consumed when its response is kept.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (req_fire_s),
        .push_data (pc_q),
        .pop       (rsp_keep_s),
        .head_data (tag_pc_s),
        .full      (tag_full_unused),
        .empty     (tag_empty_s),
        .count     (tag_count_unused)
    );

    // Instruction buffer: {pc, instruction word}.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_buf_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (rsp_keep_s),
        .push_data ({tag_pc_s, bus.imem_rsp_data}),
        .pop       (out_pop_s),
        .head_data (head_s),
        .full      (buf_full_unused),
        .empty     (buf_empty_s),
        .count     (buf_count_s)
    );

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = out_valid_s;
    assign bus.out_instr      = out_entry_s[31:0];
    assign bus.out_pc         = out_entry_s[EW-1:32];
    assign bus.out_opcode     = get_opcode(out_entry_s[31:0]);
    assign bus.out_funct3     = get_funct3(out_entry_s[31:0]);
    assign bus.out_funct7     = get_funct7(out_entry_s[31:0]);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit.
// The reference is an architectural view: the request stream and the
// delivered instruction stream must each be target, target+4, ... from the
// last reset/redirect, and every delivered word must equal memory[pc].
// Memory returns words in order with a per-request latency.
module tb_fetch_unit;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(XLEN)) bus ();

    fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    rsp_t        mem_q[$];
    int          last_due = 0;
    logic [31:0] exp_req_pc = RESET_PC;
    logic [31:0] exp_out_pc = RESET_PC;

    // stimulus knobs
    bit          rst_req      = 1'b1;
    int          ready_mode   = 0;   // 0 always, 1 random, 2 toggle
    int          oready_mode  = 0;   // 0 always, 1 held low, 2 random
    int unsigned lat_min      = 1;
    int unsigned lat_max      = 1;
    int          redir_pct    = 0;
    bit          force_redir  = 1'b0;
    logic [31:0] force_tgt    = 32'h0;
    bit          redir_on_rsp = 1'b0;

    // per-phase observations
    int          n_req;
    int          n_out;
    int          first_acc_cyc;
    logic [31:0] first_acc_addr;
    int          first_out_cyc;
    logic [31:0] first_out_pc;
    logic [6:0]  first_opc;
    logic [2:0]  first_f3;
    logic [6:0]  first_f7;
    bit          last_req_valid;
    bit          last_out_valid;
    bit          post_req_seen;
    logic [31:0] post_req_addr;
    bit          post_out_seen;
    logic [31:0] post_out_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) begin
            return 32'h00B5_0533;
        end else begin
            return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
        end
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic reset_stats();
        n_req         = 0;
        n_out         = 0;
        first_acc_cyc = -1;
        first_acc_addr = 32'h0;
        first_out_cyc = -1;
        first_out_pc  = 32'h0;
        first_opc     = 7'h0;
        first_f3      = 3'h0;
        first_f7      = 7'h0;
        post_req_seen = 1'b0;
        post_req_addr = 32'h0;
        post_out_seen = 1'b0;
        post_out_pc   = 32'h0;
    endtask

    // One clock cycle: drive inputs after the edge, settle, then check the
    // handshakes that will take place at the next edge.
    task automatic run_cycle();
        bit          drv;
        logic [31:0] tgt;
        logic [31:0] ei;
        int unsigned lat;
        int          due;
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_req;
        if (rst) begin
            mem_q.delete();
            last_due   = 0;
            exp_req_pc = RESET_PC;
            exp_out_pc = RESET_PC;
        end
        drv = !rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        bus.imem_rsp_valid = drv;
        bus.imem_rsp_data  = drv ? mem_q[0].data : 32'h0;
        if (drv) begin
            void'(mem_q.pop_front());
        end
        case (ready_mode)
            0:       bus.imem_req_ready = 1'b1;
            1:       bus.imem_req_ready = ($urandom_range(0, 1) == 1);
            default: bus.imem_req_ready = cyc[0];
        endcase
        case (oready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        if (!rst) begin
            if (force_redir) begin
                force_redir        = 1'b0;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = force_tgt;
            end else if (redir_on_rsp && drv) begin
                redir_on_rsp       = 1'b0;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = $urandom() & 32'h0000_FFFF;
            end else if ((redir_pct > 0) && (int'($urandom_range(0, 99)) < redir_pct)) begin
                tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF9 : ($urandom() & 32'h0003_FFFF);
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = tgt;
            end
        end
        #1;
        last_req_valid = bus.imem_req_valid;
        last_out_valid = bus.out_valid;
        if (rst) begin
            check_eq("rst_req_valid", 64'(bus.imem_req_valid), 64'(0));
            check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
            check_eq("rst_out_instr", 64'(bus.out_instr), 64'(0));
            check_eq("rst_out_pc", 64'(bus.out_pc), 64'(0));
        end else if (bus.redirect_valid) begin
            check_eq("redir_out_masked", 64'(bus.out_valid), 64'(0));
            check_eq("redir_no_req", 64'(bus.imem_req_valid), 64'(0));
            exp_req_pc    = bus.redirect_pc & 32'hFFFF_FFFC;
            exp_out_pc    = bus.redirect_pc & 32'hFFFF_FFFC;
            post_req_seen = 1'b0;
            post_out_seen = 1'b0;
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                check_eq("req_addr", 64'(bus.imem_req_addr), 64'(exp_req_pc));
                if (!post_req_seen) begin
                    post_req_seen = 1'b1;
                    post_req_addr = bus.imem_req_addr;
                end
                if (first_acc_cyc < 0) begin
                    first_acc_cyc  = cyc;
                    first_acc_addr = bus.imem_req_addr;
                end
                lat = $urandom_range(lat_min, lat_max);
                due = cyc + int'(lat);
                if (due <= last_due) begin
                    due = last_due + 1;
                end
                last_due = due;
                mem_q.push_back('{due: due, data: mem_word(bus.imem_req_addr)});
                check_eq("outstanding_bound", 64'(mem_q.size() <= DEPTH), 64'(1));
                n_req++;
                exp_req_pc = exp_req_pc + 32'd4;
            end
            if (bus.out_valid && (first_out_cyc < 0)) begin
                first_out_cyc = cyc;
                first_out_pc  = bus.out_pc;
                first_opc     = bus.out_opcode;
                first_f3      = bus.out_funct3;
                first_f7      = bus.out_funct7;
            end
            if (bus.out_valid && bus.out_ready) begin
                ei = mem_word(exp_out_pc);
                check_eq("out_pc", 64'(bus.out_pc), 64'(exp_out_pc));
                check_eq("out_instr", 64'(bus.out_instr), 64'(ei));
                check_eq("out_opcode", 64'(bus.out_opcode), 64'(ei[6:0]));
                check_eq("out_funct3", 64'(bus.out_funct3), 64'(ei[14:12]));
                check_eq("out_funct7", 64'(bus.out_funct7), 64'(ei[31:25]));
                if (!post_out_seen) begin
                    post_out_seen = 1'b1;
                    post_out_pc   = bus.out_pc;
                end
                exp_out_pc = exp_out_pc + 32'd4;
                n_out++;
            end
        end
    endtask

    task automatic apply_reset();
        rst_req = 1'b1;
        repeat (2) run_cycle();
        rst_req = 1'b0;
        reset_stats();
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        reset_stats();

        // Latency-1 memory, everything ready: first delivery two cycles after accept.
        ready_mode = 0; oready_mode = 0; lat_min = 1; lat_max = 1; redir_pct = 0;
        apply_reset();
        repeat (12) run_cycle();
        check_eq("t1_first_addr", 64'(first_acc_addr), 64'(RESET_PC));
        check_eq("t1_latency", 64'(first_out_cyc - first_acc_cyc), 64'(2));
        check_eq("t1_first_pc", 64'(first_out_pc), 64'(RESET_PC));
        check_eq("t1_add_opcode", 64'(first_opc), 64'(7'b0110011));
        check_eq("t1_add_funct3", 64'(first_f3), 64'(3'b000));
        check_eq("t1_add_funct7", 64'(first_f7), 64'(7'b0000000));
        check_eq("t1_progress", 64'(n_out >= 6), 64'(1));

        // Decode stalled: exactly DEPTH fetches, then no more requests.
        apply_reset();
        oready_mode = 1;
        repeat (10) run_cycle();
        check_eq("t2_req_count", 64'(n_req), 64'(DEPTH));
        check_eq("t2_req_stalled", 64'(last_req_valid), 64'(0));
        check_eq("t2_buf_valid", 64'(last_out_valid), 64'(1));
        oready_mode = 0;
        repeat (10) run_cycle();
        check_eq("t2_resume", 64'(n_out >= 3), 64'(1));

        // Redirect to 0x103 with two fetches in flight at latency 3.
        lat_min = 3; lat_max = 3;
        apply_reset();
        repeat (2) run_cycle();
        check_eq("t3_in_flight", 64'(n_req), 64'(2));
        force_tgt = 32'h0000_0103; force_redir = 1'b1;
        run_cycle();
        repeat (20) run_cycle();
        check_eq("t3_new_req_seen", 64'(post_req_seen), 64'(1));
        check_eq("t3_new_req_addr", 64'(post_req_addr), 64'(32'h100));
        check_eq("t3_first_out_pc", 64'(post_out_pc), 64'(32'h100));

        // Toggling request ready with redirects landing on response cycles.
        ready_mode = 2; lat_min = 2; lat_max = 2;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            redir_on_rsp = 1'b1;
            repeat (30) run_cycle();
        end
        check_eq("t5_progress", 64'(n_out > 0), 64'(1));

        // Fully random traffic with random redirects (including PC wraparound).
        ready_mode = 1; oready_mode = 2; lat_min = 1; lat_max = 4; redir_pct = 6;
        apply_reset();
        repeat (3000) run_cycle();
        check_eq("t4_progress", 64'(n_out > 100), 64'(1));
        redir_pct = 0;

        // Reset while the buffer is full, then restart from RESET_PC.
        ready_mode = 0; lat_min = 1; lat_max = 1;
        apply_reset();
        oready_mode = 1;
        repeat (8) run_cycle();
        check_eq("t6_buf_full", 64'(last_out_valid), 64'(1));
        rst_req = 1'b1;
        run_cycle();
        rst_req = 1'b0;
        reset_stats();
        run_cycle();
        check_eq("t6_out_cleared", 64'(last_out_valid), 64'(0));
        check_eq("t6_restart_req", 64'(last_req_valid), 64'(1));
        check_eq("t6_restart_addr", 64'(first_acc_addr), 64'(RESET_PC));
        oready_mode = 0;
        repeat (10) run_cycle();
        check_eq("t6_progress", 64'(n_out >= 3), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
